alu_decode: RTL and testbench
=============================

# alu_decode

Front-end decode stage for the integer ALU. It accepts 32-bit RV32I instructions on a valid/ready stream and extracts register indices and the immediate. It produces the 10-bit ALU operation code the ALU consumes, and presents the result on a registered valid/ready output stream. A 2-entry skid buffer gives full throughput with no combinational path from `out_ready` to `in_ready`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `flush`  in  1  synchronous; discards all buffered entries.
- `in_valid`  in  1  instruction valid.
- `in_ready`  out  1  registered; stage can accept.
- `in_instr`  in  32  instruction word.
- `out_valid`  out  1  decoded entry valid.
- `out_ready`  in  1  consumer accepts.
- `alu_op`  out  10  ALU operation code.
- `rs1`, `rs2`, `rd`  out  5 each  register indices.
- `imm`  out  32  immediate operand.
- `use_imm`  out  1  operand 2 comes from `imm`, not `rs2`.
- `reg_write`  out  1  instruction writes `rd`.
- `illegal`  out  1  instruction not supported.
- `illegal_cnt`  out  16  saturating count of illegal instructions accepted.

## Operation
- Decoded opcodes: OP (0110011) and OP-IMM (0010011). All other opcodes are illegal.
- `alu_op` encoding: bits [2:0] = funct3. Bits [9:3] = 7'b0010100 for SUB/SRA/SRAI, otherwise 0.
  - ADD 0x000, SUB 0x0A0, SLL 0x001, SLT 0x002, XOR 0x004, SRL 0x005, SRA 0x0A5, OR 0x006, AND 0x007.
- OP: `use_imm`=0, `imm`=0.
  - Legal if funct7=0x00 for any funct3 except 3, or if funct7=0x20 with funct3 0 or 5.
- OP-IMM: `use_imm`=1.
  - ADDI/SLTI/XORI/ORI/ANDI: `imm` = sign-extended instr[31:20].
  - SLLI requires instr[31:25]=0x00. SRLI requires 0x00. SRAI requires 0x20.
  - Shift `imm` = zero-extended instr[24:20].
  - For ADDI and the other non-shift ops, `alu_op` bits [9:3] are 0 regardless of the immediate.
- Unsupported: SLTU and SLTIU (funct3=3) are illegal. The ALU has no SLTU/SLTIU implementation.
- Illegal entries: `illegal`=1, `alu_op`=0, `reg_write`=0, `use_imm`=0, `imm`=0.
  - `rs1`/`rs2`/`rd` still carry the raw instruction fields.
- Legal entries: `reg_write`=1.
- `illegal_cnt` increments once per illegal instruction accepted at the input handshake.
  - Saturates at 0xFFFF.
  - Cleared only by `rst`; unaffected by `flush`.

## Timing
- Input transfer: `in_valid && in_ready` at a rising edge. Output transfer: `out_valid && out_ready` at a rising edge.
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- State machine:
  - EMPTY: main register empty. `in_ready`=1, `out_valid`=0.
  - ONE: main register holds an entry. `in_ready`=1, `out_valid`=1.
  - FULL: main and skid registers both hold entries. `in_ready`=0, `out_valid`=1.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without output transfer.
  - ONE→EMPTY on output transfer without accept.
  - ONE→ONE on simultaneous accept and output transfer; the main register is reloaded.
  - FULL→ONE on output transfer; the skid entry moves to main.
- Output order always equals input order.
- Output fields are held stable while `out_valid && !out_ready`.
- `flush`:
  - Next state is EMPTY.
  - An input accepted in the same cycle is dropped and is not counted.
  - Any output transfer in the flush cycle still counts as delivered.
- `rst` wins over `flush`. After reset:
  - `out_valid`=0 and `in_ready`=1.
  - All data outputs are 0.
  - `illegal_cnt`=0.
- Reset mid-stream discards all entries.

## Structure
- Shared package `alu_pkg` holds:
  - `alu_op_t` (logic [9:0]) and the nine opcode constants listed above.
  - Opcode constants `OPC_OP`=7'b0110011 and `OPC_OP_IMM`=7'b0010011.
  - Packed struct `alu_dec_t` {alu_op, rs1, rs2, rd, imm, use_imm, reg_write, illegal}.
- Combinational decode logic lives in `alu_decode`.
- Buffering lives in the sub-module `skid_buffer`, parameterised on payload width and carrying `alu_dec_t`. It is reused for later pipeline stages.

## Test plan
- Reset, then 0x002081B3 (ADD x3,x1,x2) with `out_ready`=1 → 1 cycle later: `alu_op`=0x000, `rs1`=1, `rs2`=2, `rd`=3, `use_imm`=0, `reg_write`=1.
- 0x407302B3 (SUB x5,x6,x7) → `alu_op`=0x0A0, `rd`=5. 0x40315113 (SRAI x2,x2,3) → `alu_op`=0x0A5, `imm`=3, `use_imm`=1.
- 0xFFF00093 (ADDI x1,x0,-1) → `alu_op`=0x000, `imm`=0xFFFFFFFF. 0x0020B1B3 (SLTU) → `illegal`=1, `reg_write`=0, `illegal_cnt`=1.
- `out_ready`=0 and push 3 instructions → 2 accepted, then `in_ready`=0. Raise `out_ready` → all 3 delivered in order on consecutive cycles.
- With FULL, assert `flush` while `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, nothing delivered, `illegal_cnt` unchanged.
- Stream 0x10000 illegal words (0x00000000) → `illegal_cnt` holds at 0xFFFF. Assert `rst` mid-stream → all outputs 0, `in_ready`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the integer ALU front end.
//   alu_op_t   - 10-bit ALU operation code consumed by the ALU.
//   ALU_*      - the nine supported operation codes.
//   OPC_*      - the two decoded RV32I major opcodes.
//   alu_dec_t  - one decoded instruction as it travels down the pipeline.
package alu_pkg;

    typedef logic [9:0] alu_op_t;

    // Upper bits that distinguish SUB/SRA/SRAI from ADD/SRL/SRLI.
    localparam logic [6:0] ALU_ALT_BITS = 7'b0010100;
    localparam logic [6:0] FUNCT7_ALT   = 7'h20;
    localparam logic [6:0] FUNCT7_BASE  = 7'h00;

    localparam alu_op_t ALU_ADD = 10'h000;
    localparam alu_op_t ALU_SUB = 10'h0A0;
    localparam alu_op_t ALU_SLL = 10'h001;
    localparam alu_op_t ALU_SLT = 10'h002;
    localparam alu_op_t ALU_XOR = 10'h004;
    localparam alu_op_t ALU_SRL = 10'h005;
    localparam alu_op_t ALU_SRA = 10'h0A5;
    localparam alu_op_t ALU_OR  = 10'h006;
    localparam alu_op_t ALU_AND = 10'h007;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        reg_write;
        logic        illegal;
    } alu_dec_t;

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: 2-entry valid/ready buffer with fully registered handshakes.
//   clk, rst (sync, active-high), flush (sync, drops every entry)
//   in_valid/in_ready/in_data   - upstream stream; in_ready is a flop
//   out_valid/out_ready/out_data - downstream stream; all three outputs are flops
// The main register always feeds the outputs; the skid register catches the
// one extra word that can arrive while in_ready is still high but the
// consumer has stalled, so out_ready never reaches in_ready combinationally.
module skid_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [W-1:0]   main_r;
    logic [W-1:0]   skid_r;
    logic           accept_s;
    logic           xfer_s;
    logic           main_load_s;
    logic           main_from_skid_s;
    logic           skid_load_s;

    assign accept_s = in_valid && in_ready_r;
    assign xfer_s   = out_valid_r && out_ready;

    // Next-state and register-load decisions.
    always_comb begin
        state_next_s     = state_r;
        main_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        if (flush) begin
            // Any word accepted this cycle is dropped along with the rest.
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_next_s = ST_ONE;
                        main_load_s  = 1'b1;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && xfer_s) begin
                        state_next_s = ST_ONE;
                        main_load_s  = 1'b1;
                    end else if (accept_s) begin
                        state_next_s = ST_FULL;
                        skid_load_s  = 1'b1;
                    end else if (xfer_s) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (xfer_s) begin
                        state_next_s     = ST_ONE;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_next_s = ST_FULL;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register plus registered handshake flags derived from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != ST_FULL);
            out_valid_r <= (state_next_s != ST_EMPTY);
        end
    end

    // Payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r <= {W{1'b0}};
            skid_r <= {W{1'b0}};
        end else begin
            if (main_load_s) begin
                main_r <= in_data;
            end else if (main_from_skid_s) begin
                main_r <= skid_r;
            end
            if (skid_load_s) begin
                skid_r <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;

endmodule

// File: rtl/alu_decode.sv
// alu_decode: RV32I OP / OP-IMM decode stage for the integer ALU.
//   clk, rst (sync, active-high), flush (sync, drops buffered entries)
//   in_valid/in_ready/in_instr  - instruction stream in
//   out_valid/out_ready         - decoded stream out (1-cycle latency)
//   alu_op, rs1, rs2, rd, imm, use_imm, reg_write, illegal - decoded fields
//   illegal_cnt                 - saturating count of accepted illegal words
module alu_decode
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  alu_op,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        use_imm,
    output logic        reg_write,
    output logic        illegal,
    output logic [15:0] illegal_cnt
);

    localparam int DEC_W = $bits(alu_dec_t);

    alu_dec_t    dec_s;
    alu_dec_t    out_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic        legal_s;
    logic        alt_s;
    logic        accept_s;
    logic [15:0] illegal_cnt_r;

    assign opcode_s = in_instr[6:0];
    assign funct3_s = in_instr[14:12];
    assign funct7_s = in_instr[31:25];

    // Instruction decode; illegal words keep only the raw register fields.
    always_comb begin
        legal_s       = 1'b0;
        alt_s         = 1'b0;
        dec_s         = '0;
        dec_s.rs1     = in_instr[19:15];
        dec_s.rs2     = in_instr[24:20];
        dec_s.rd      = in_instr[11:7];
        case (opcode_s)
            OPC_OP: begin
                if (funct7_s == FUNCT7_BASE) begin
                    legal_s = (funct3_s != 3'd3);
                end else if (funct7_s == FUNCT7_ALT) begin
                    legal_s = (funct3_s == 3'd0) || (funct3_s == 3'd5);
                    alt_s   = 1'b1;
                end else begin
                    legal_s = 1'b0;
                end
                dec_s.use_imm = 1'b0;
                dec_s.imm     = 32'd0;
            end
            OPC_OP_IMM: begin
                case (funct3_s)
                    3'd1: begin
                        legal_s = (funct7_s == FUNCT7_BASE);
                    end
                    3'd5: begin
                        legal_s = (funct7_s == FUNCT7_BASE) || (funct7_s == FUNCT7_ALT);
                        alt_s   = (funct7_s == FUNCT7_ALT);
                    end
                    3'd3: begin
                        legal_s = 1'b0;
                    end
                    default: begin
                        legal_s = 1'b1;
                    end
                endcase
                dec_s.use_imm = 1'b1;
                // Shifts carry a 5-bit shamt; the rest a signed 12-bit value.
                if ((funct3_s == 3'd1) || (funct3_s == 3'd5)) begin
                    dec_s.imm = {27'd0, in_instr[24:20]};
                end else begin
                    dec_s.imm = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
        if (legal_s) begin
            dec_s.alu_op    = {(alt_s ? ALU_ALT_BITS : 7'd0), funct3_s};
            dec_s.reg_write = 1'b1;
            dec_s.illegal   = 1'b0;
        end else begin
            dec_s.alu_op    = ALU_ADD;
            dec_s.imm       = 32'd0;
            dec_s.use_imm   = 1'b0;
            dec_s.reg_write = 1'b0;
            dec_s.illegal   = 1'b1;
        end
    end

    skid_buffer #(
        .W (DEC_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_s)
    );

    // Words dropped by a same-cycle flush are not counted.
    assign accept_s = in_valid && in_ready && !flush;

    // Saturating illegal-instruction counter; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt_r <= 16'd0;
        end else if (accept_s && dec_s.illegal && (illegal_cnt_r != 16'hFFFF)) begin
            illegal_cnt_r <= illegal_cnt_r + 16'd1;
        end
    end

    assign alu_op      = out_s.alu_op;
    assign rs1         = out_s.rs1;
    assign rs2         = out_s.rs2;
    assign rd          = out_s.rd;
    assign imm         = out_s.imm;
    assign use_imm     = out_s.use_imm;
    assign reg_write   = out_s.reg_write;
    assign illegal     = out_s.illegal;
    assign illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_alu_decode.sv
// tb_alu_decode: directed self-checking bench for alu_decode.
module tb_alu_decode;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        illegal;
    logic [15:0] illegal_cnt;

    int tests;
    int fails;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h407302B3;
    localparam logic [31:0] I_SRAI = 32'h40315113;
    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_SLTU = 32'h0020B1B3;

    alu_decode dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op      (alu_op),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .imm         (imm),
        .use_imm     (use_imm),
        .reg_write   (reg_write),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_alu_op", {22'd0, alu_op}, 32'd0);
        check("rst_imm", imm, 32'd0);
        check("rst_cnt", {16'd0, illegal_cnt}, 32'd0);

        // Streaming with consumer always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = I_ADD;
        step();
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_op", {22'd0, alu_op}, 32'h000);
        check("add_rs1", {27'd0, rs1}, 32'd1);
        check("add_rs2", {27'd0, rs2}, 32'd2);
        check("add_rd", {27'd0, rd}, 32'd3);
        check("add_use_imm", {31'd0, use_imm}, 32'd0);
        check("add_reg_write", {31'd0, reg_write}, 32'd1);
        check("add_illegal", {31'd0, illegal}, 32'd0);

        in_instr = I_SUB;
        step();
        check("sub_op", {22'd0, alu_op}, 32'h0A0);
        check("sub_rd", {27'd0, rd}, 32'd5);

        in_instr = I_SRAI;
        step();
        check("srai_op", {22'd0, alu_op}, 32'h0A5);
        check("srai_imm", imm, 32'd3);
        check("srai_use_imm", {31'd0, use_imm}, 32'd1);

        in_instr = I_ADDI;
        step();
        check("addi_op", {22'd0, alu_op}, 32'h000);
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_rd", {27'd0, rd}, 32'd1);

        in_instr = I_SLTU;
        step();
        check("sltu_illegal", {31'd0, illegal}, 32'd1);
        check("sltu_reg_write", {31'd0, reg_write}, 32'd0);
        check("sltu_op", {22'd0, alu_op}, 32'd0);
        check("sltu_rd_raw", {27'd0, rd}, 32'd3);
        check("sltu_cnt", {16'd0, illegal_cnt}, 32'd1);

        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: three pushes, only two fit.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_ADD;
        step();
        check("bp_ready_one", {31'd0, in_ready}, 32'd1);
        in_instr = I_SUB;
        step();
        check("bp_ready_full", {31'd0, in_ready}, 32'd0);
        check("bp_valid_full", {31'd0, out_valid}, 32'd1);
        in_instr = I_SRAI;
        step();
        check("bp_still_full", {31'd0, in_ready}, 32'd0);
        check("bp_hold_op", {22'd0, alu_op}, 32'h000);
        check("bp_hold_rd", {27'd0, rd}, 32'd3);
        out_ready = 1'b1;
        step();
        check("bp_second_op", {22'd0, alu_op}, 32'h0A0);
        check("bp_second_valid", {31'd0, out_valid}, 32'd1);
        step();
        check("bp_third_op", {22'd0, alu_op}, 32'h0A5);
        check("bp_third_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Flush from FULL with an input offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_ADD;
        step();
        in_instr = I_SUB;
        step();
        check("fl_full", {31'd0, in_ready}, 32'd0);
        flush    = 1'b1;
        in_instr = I_SLTU;
        step();
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_ready", {31'd0, in_ready}, 32'd1);
        check("fl_cnt", {16'd0, illegal_cnt}, 32'd1);
        // Illegal word accepted in a flush cycle is dropped and not counted.
        step();
        check("fl_drop_valid", {31'd0, out_valid}, 32'd0);
        check("fl_drop_cnt", {16'd0, illegal_cnt}, 32'd1);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();

        // Counter saturation with a continuous illegal stream.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00000000;
        for (int i = 0; i < 32'h10000; i++) begin
            step();
        end
        check("sat_cnt", {16'd0, illegal_cnt}, 32'h0000FFFF);
        check("sat_illegal", {31'd0, illegal}, 32'd1);
        check("sat_valid", {31'd0, out_valid}, 32'd1);

        // Reset mid-stream.
        rst = 1'b1;
        step();
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_ready", {31'd0, in_ready}, 32'd1);
        check("mrst_cnt", {16'd0, illegal_cnt}, 32'd0);
        check("mrst_illegal", {31'd0, illegal}, 32'd0);
        check("mrst_rd", {27'd0, rd}, 32'd0);
        check("mrst_imm", imm, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
